led_uart_reporter: RTL and testbench

Downstream consumer of the processor's 32-bit `led` output. It captures every change of the value into a small FIFO. Each captured word is serialized over a UART TX line as 8 uppercase hex ASCII characters followed by CR LF. The block sits beside the processor at board top level and gives a trace of committed WB results without a logic analyser.

---
 rtl/led_uart_reporter_if.sv | 14 +
 rtl/led_uart_reporter.sv | 151 +++++++++++++++
 tb/tb_led_uart_reporter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/led_uart_reporter_if.sv
// Connection between the processor's led register and the UART trace reporter.
// The master side drives led_in; the slave side is the reporter.
interface led_uart_reporter_if #(
    parameter int FIFO_AW = 4
);
    logic [31:0]      led_in;
    logic             txd;
    logic             busy;
    logic [FIFO_AW:0] fifo_count;
    logic [15:0]      drop_cnt;

    modport master (output led_in, input txd, busy, fifo_count, drop_cnt);
    modport slave  (input led_in, output txd, busy, fifo_count, drop_cnt);
endinterface

// File: rtl/led_uart_reporter.sv
// Captures every change of the processor led value into a FIFO and prints each
// queued word over an 8N1 UART as eight uppercase hex characters plus CR LF.
module led_uart_reporter #(
    parameter int BAUD_DIV = 868,
    parameter int FIFO_AW  = 4
) (
    input logic                clk,
    input logic                rst,
    led_uart_reporter_if.slave bus
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CW    = FIFO_AW + 1;
    localparam int BW    = $clog2(BAUD_DIV);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state, state_n;
    logic [BW-1:0]      baud_cnt, baud_n;
    logic [2:0]         bit_idx, bit_n;
    logic [3:0]         char_idx, char_n;
    logic [31:0]        shift_word;
    logic [31:0]        last_val;
    logic [31:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]      count;
    logic [15:0]        drops;
    logic               push_req, push_ok, pop, bit_tick;
    logic [3:0]         nib;
    logic [7:0]         char_byte;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_req = !rst && (bus.led_in != last_val);
    assign push_ok  = push_req && ((count != CW'(DEPTH)) || pop);
    assign bit_tick = (baud_cnt == BW'(BAUD_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            last_val <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drops    <= '0;
        end else begin
            if (push_req)
                last_val <= bus.led_in;
            if (push_ok)
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            if (push_ok && !pop)
                count <= count + CW'(1);
            else if (!push_ok && pop)
                count <= count - CW'(1);
            if (push_req && !push_ok && drops != 16'hFFFF)
                drops <= drops + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= bus.led_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            char_idx   <= '0;
            shift_word <= '0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_idx  <= bit_n;
            char_idx <= char_n;
            if (pop)
                shift_word <= mem[rd_ptr];
        end
    end

    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_idx;
        char_n  = char_idx;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                baud_n = '0;
                if (count != '0) begin
                    pop     = 1'b1;
                    char_n  = 4'd0;
                    state_n = START;
                end
            end
            START: begin
                if (bit_tick) begin
                    baud_n  = '0;
                    bit_n   = 3'd0;
                    state_n = DATA;
                end else begin
                    baud_n = baud_cnt + BW'(1);
                end
            end
            DATA: begin
                if (bit_tick) begin
                    baud_n = '0;
                    if (bit_idx == 3'd7)
                        state_n = STOP;
                    else
                        bit_n = bit_idx + 3'd1;
                end else begin
                    baud_n = baud_cnt + BW'(1);
                end
            end
            STOP: begin
                if (bit_tick) begin
                    baud_n = '0;
                    if (char_idx == 4'd9) begin
                        state_n = IDLE;
                    end else begin
                        char_n  = char_idx + 4'd1;
                        state_n = START;
                    end
                end else begin
                    baud_n = baud_cnt + BW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Characters 0..7 walk the nibbles from the top; 8 and 9 are CR and LF.
    always_comb begin
        nib = 4'(shift_word >> {3'd7 - char_idx[2:0], 2'b00});
        if (nib < 4'd10)
            char_byte = {4'h3, nib};
        else
            char_byte = 8'h37 + {4'h0, nib};
        if (char_idx == 4'd8)
            char_byte = 8'h0D;
        else if (char_idx == 4'd9)
            char_byte = 8'h0A;
    end

    assign bus.txd        = (state == START) ? 1'b0 :
                            (state == DATA)  ? char_byte[bit_idx] : 1'b1;
    assign bus.busy       = (state != IDLE);
    assign bus.fifo_count = count;
    assign bus.drop_cnt   = drops;
endmodule

// File: tb/tb_led_uart_reporter.sv
// Directed and random checks of led_uart_reporter against a word-level model:
// a queue of pending words plus a countdown of the cycles left in the current word.
module tb_led_uart_reporter;
    localparam int BAUD_DIV    = 4;
    localparam int FIFO_AW     = 2;
    localparam int DEPTH       = 2 ** FIFO_AW;
    localparam int CHAR_CYCLES = 10 * BAUD_DIV;
    localparam int WORD_CYCLES = 10 * CHAR_CYCLES;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    led_uart_reporter_if #(.FIFO_AW(FIFO_AW)) bus();

    led_uart_reporter #(.BAUD_DIV(BAUD_DIV), .FIFO_AW(FIFO_AW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] fifo_m[$];
    logic [31:0] last_m = '0;
    logic [31:0] cur_word = '0;
    int          drop_m = 0;
    int          busy_left = 0;
    logic [7:0]  exp_bytes[$];
    logic [7:0]  rx_bytes[$];
    int          frame_errs = 0;
    int          busy_cycles = 0;

    function automatic logic [7:0] char_of(logic [31:0] w, int ch);
        int n;
        if (ch == 8) return 8'h0D;
        if (ch == 9) return 8'h0A;
        n = int'((w >> (28 - 4 * ch)) & 32'hF);
        if (n < 10) return 8'(n + 48);
        return 8'(n - 10 + 65);
    endfunction

    // Expected line level from the position inside the current word.
    function automatic logic exp_txd();
        logic [7:0] cb;
        int e, slot;
        if (busy_left == 0) return 1'b1;
        e    = WORD_CYCLES - busy_left;
        slot = (e % CHAR_CYCLES) / BAUD_DIV;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        cb = char_of(cur_word, e / CHAR_CYCLES);
        return cb[slot - 1];
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("[TB] check %s", tag);
        end
    endtask

    task automatic modelEdge(input logic r, input logic [31:0] v);
        if (r) begin
            fifo_m.delete();
            last_m    = '0;
            drop_m    = 0;
            busy_left = 0;
        end else begin
            if (busy_left == 0 && fifo_m.size() > 0) begin
                cur_word  = fifo_m.pop_front();
                busy_left = WORD_CYCLES;
                for (int ch = 0; ch < 10; ch++)
                    exp_bytes.push_back(char_of(cur_word, ch));
            end else if (busy_left > 0) begin
                busy_left--;
            end
            if (v != last_m) begin
                last_m = v;
                if (fifo_m.size() < DEPTH)
                    fifo_m.push_back(v);
                else if (drop_m < 65535)
                    drop_m++;
            end
        end
    endtask

    task automatic checkOutput();
        check("txd", bus.txd, exp_txd());
        check("busy", bus.busy, busy_left > 0);
        check("fifo_count", bus.fifo_count, fifo_m.size());
        check("drop_cnt", bus.drop_cnt, drop_m);
        if (bus.busy === 1'b1) busy_cycles++;
    endtask

    task automatic applyStimulus(input logic r, input logic [31:0] v);
        rst        = r;
        bus.led_in = v;
        @(posedge clk);
        modelEdge(r, v);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic waitIdle(input logic [31:0] v);
        for (int i = 0; i < 10 * WORD_CYCLES; i++) begin
            if (busy_left == 0 && fifo_m.size() == 0) break;
            applyStimulus(1'b0, v);
        end
        repeat (3) applyStimulus(1'b0, v);
    endtask

    task automatic checkConst(string tag, logic [79:0] want);
        check({tag, "_nbytes"}, rx_bytes.size(), 10);
        if (rx_bytes.size() == 10)
            for (int i = 0; i < 10; i++)
                check({tag, "_byte"}, rx_bytes[i], want[79 - 8 * i -: 8]);
    endtask

    task automatic checkBytes(string tag);
        check({tag, "_nbytes"}, rx_bytes.size(), exp_bytes.size());
        if (rx_bytes.size() == exp_bytes.size())
            for (int i = 0; i < rx_bytes.size(); i++)
                check({tag, "_byte"}, rx_bytes[i], exp_bytes[i]);
        rx_bytes.delete();
        exp_bytes.delete();
    endtask

    // UART receiver sampling mid-bit; a frame cut short by a reset is discarded.
    initial begin : uart_monitor
        logic [7:0] b;
        logic       aborted;
        forever begin
            @(negedge clk);
            if (bus.txd === 1'b0) begin
                aborted = 1'b0;
                b       = '0;
                for (int c = 1; c <= 9 * BAUD_DIV + BAUD_DIV / 2; c++) begin
                    @(negedge clk);
                    if (bus.busy !== 1'b1) aborted = 1'b1;
                    if ((c % BAUD_DIV) == BAUD_DIV / 2) begin
                        if (c / BAUD_DIV >= 1 && c / BAUD_DIV <= 8)
                            b[c / BAUD_DIV - 1] = bus.txd;
                        else if (c / BAUD_DIV == 9 && !aborted && bus.txd !== 1'b1)
                            frame_errs++;
                    end
                end
                if (!aborted) rx_bytes.push_back(b);
            end
        end
    end

    initial begin
        logic [31:0] led_v;
        bus.led_in = '0;

        $display("[TB] reset with led_in held at 12345678");
        repeat (3) applyStimulus(1'b1, 32'h1234_5678);
        applyStimulus(1'b0, 32'h1234_5678);
        check("capture_after_reset", bus.fifo_count, 1);
        applyStimulus(1'b0, 32'h1234_5678);
        check("start_bit_after_pop", bus.txd, 0);
        waitIdle(32'h1234_5678);
        checkConst("word_12345678", 80'h3132_3334_3536_3738_0D0A);
        checkBytes("word_12345678");

        $display("[TB] single word 0000002A");
        repeat (2) applyStimulus(1'b1, 32'h0);
        busy_cycles = 0;
        applyStimulus(1'b0, 32'h2A);
        waitIdle(32'h2A);
        check("busy_cycles", busy_cycles, WORD_CYCLES);
        checkConst("word_2A", 80'h3030_3030_3030_3241_0D0A);
        checkBytes("word_2A");

        $display("[TB] hex mapping FEDCBA98");
        repeat (2) applyStimulus(1'b1, 32'h0);
        applyStimulus(1'b0, 32'hFEDC_BA98);
        waitIdle(32'hFEDC_BA98);
        checkConst("word_FEDCBA98", 80'h4645_4443_4241_3938_0D0A);
        checkBytes("word_FEDCBA98");

        $display("[TB] overflow burst 1..10");
        repeat (2) applyStimulus(1'b1, 32'h0);
        for (int v = 1; v <= 10; v++) applyStimulus(1'b0, 32'(v));
        check("burst_drops", bus.drop_cnt, 5);
        check("burst_full", bus.fifo_count, DEPTH);
        for (int i = 0; i < 2 * WORD_CYCLES; i++) begin
            if (busy_left == 0 && fifo_m.size() > 0) break;
            applyStimulus(1'b0, 32'd10);
        end
        applyStimulus(1'b0, 32'd11);
        check("push_with_pop_drops", bus.drop_cnt, 5);
        check("push_with_pop_count", bus.fifo_count, DEPTH);
        waitIdle(32'd11);
        check("burst_nbytes", rx_bytes.size(), 60);
        if (rx_bytes.size() == 60)
            for (int w = 0; w < 5; w++)
                check("burst_order", rx_bytes[10 * w + 7], 8'h31 + 8'(w));
        checkBytes("burst");

        $display("[TB] constant led_in for 1000 cycles");
        repeat (2) applyStimulus(1'b1, 32'h0);
        repeat (1000) applyStimulus(1'b0, 32'h55AA_00FF);
        check("repeat_nbytes", rx_bytes.size(), 10);
        checkBytes("repeat");

        $display("[TB] random led_in traffic");
        repeat (2) applyStimulus(1'b1, 32'h0);
        led_v = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) led_v = $urandom;
            applyStimulus(1'b0, led_v);
        end
        waitIdle(led_v);
        checkBytes("random");

        $display("[TB] reset during char 3");
        repeat (2) applyStimulus(1'b1, 32'h0);
        applyStimulus(1'b0, 32'hA5A5_0001);
        applyStimulus(1'b0, 32'hA5A5_0002);
        for (int i = 0; i < 2 * WORD_CYCLES; i++) begin
            if (busy_left > 0 && WORD_CYCLES - busy_left == 3 * CHAR_CYCLES + 3 * BAUD_DIV + 1) break;
            applyStimulus(1'b0, 32'hA5A5_0002);
        end
        check("midreset_in_char3", WORD_CYCLES - busy_left, 3 * CHAR_CYCLES + 3 * BAUD_DIV + 1);
        applyStimulus(1'b1, 32'h0);
        check("midreset_txd", bus.txd, 1);
        check("midreset_busy", bus.busy, 0);
        check("midreset_count", bus.fifo_count, 0);
        repeat (2 * CHAR_CYCLES) applyStimulus(1'b0, 32'h0);
        rx_bytes.delete();
        exp_bytes.delete();
        busy_cycles = 0;
        repeat (500) applyStimulus(1'b0, 32'h0);
        check("midreset_silent", rx_bytes.size(), 0);
        check("midreset_idle", busy_cycles, 0);

        check("frame_errors", frame_errs, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
